instr_encoder: RTL
==================

// Module: instr_encoder
// PURPOSE
//  Inverse of the control decoder: packs an operation descriptor into a 32-bit RV32I word and writes it into
//  instruction memory at an auto-incrementing address. Used by the program loader / self-test sequencer.
//  Holds one encoded word; backpressured by the imem write port.
// PARAMETERS
//  ADDR_W     10  imem word-address width
//  BASE_ADDR  0   first word address after reset/restart
// PORTS
//  clk          in   1       clock; all logic on rising edge
//  reset        in   1       synchronous, active-high
//  restart      in   1       sync: return to BASE_ADDR, drop pending word, clear err/full
//  in_valid     in   1       descriptor valid
//  in_ready     out  1       descriptor accepted when in_valid&in_ready
//  in_class     in   4       0 OPIMM,1 OP,2 LOAD,3 STORE,4 BRANCH,5 JALR,6 JAL,7 LUI,8 AUIPC
//  in_funct3    in   3       funct3 field
//  in_alt       in   1       funct7[5] (sub/sra/srai)
//  in_rd/in_rs1/in_rs2  in  5 each  register indices
//  in_imm       in   32      immediate; only bits of the format used
//  imem_we      out  1       write request, held until imem_ready
//  imem_ready   in   1       write completes when imem_we&imem_ready
//  imem_addr    out  ADDR_W  word address
//  imem_wdata   out  32      encoded instruction
//  count        out  ADDR_W+1 words written since reset/restart
//  full         out  1       address space exhausted
//  err          out  1       sticky: illegal descriptor seen
// BEHAVIOUR
//  Reset: imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, count=0, full=0, err=0. Priority reset>restart>op.
//  States: EMPTY (no word held), HOLD (imem_we=1), FULL (stop). in_ready = !full && (EMPTY || imem_ready).
//  Accept at edge N -> imem_we=1 with wdata from cycle N+1; combinational path in_*->imem_* forbidden.
//  HOLD: addr/wdata stable until imem_ready. On completion: count+1, addr+1; same-edge accept -> stays HOLD
//   with new word (back-to-back, one word per cycle); else EMPTY.
//  Completion at addr = 2^ADDR_W-1: full=1, go FULL, in_ready=0; no wrap. Leaves only on restart/reset.
//  restart mid-HOLD: imem_we drops next cycle, word discarded, count not incremented.
//  Formats (opcode by class 13,33,03,23,63,67,6F,37,17):
//   I: imm[11:0]|rs1|f3|rd; shift (OPIMM f3=001/101): {0,alt,5'b0}|imm[4:0]|rs1|f3|rd.
//   R: {0,alt,5'b0}|rs2|rs1|f3|rd. S: imm[11:5]|rs2|rs1|f3|imm[4:0].
//   B: imm[12]|imm[10:5]|rs2|rs1|f3|imm[4:1]|imm[11]. J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd.
//   U: imm[31:12]|rd. Unused imm bits ignored, no range check.
//  Illegal (writes NOP 0x00000013, sets err; address still advances): class>8; alt=1 except OP f3=000/101
//   or OPIMM f3=101; LOAD f3 in {011,110,111}; STORE f3>010; BRANCH f3 in {010,011}; JALR f3!=000.
//   in_funct3, in_alt ignored for JAL/LUI/AUIPC.
// TESTING
//  addi x1,x0,5 (cls0,f3 0,rd1,imm5) -> next cycle imem_we=1, addr 0, wdata 0x00500093
//  sub x3,x1,x2 (cls1,alt1); sw x2,8(x1) (cls3,f3 2) back-to-back, imem_ready=1 -> 0x402081B3 @0, 0x0020A423 @1
//  beq x1,x2,imm=0xFFFFFFFC -> 0xFE208EE3; jal x1,imm=0x800 -> 0x001000EF
//  imem_ready low 3 cycles -> addr/wdata stable, in_ready=0, count unchanged until ready
//  cls4 f3 2 -> wdata 0x00000013, err=1 sticky, count increments
//  ADDR_W=2: 4 writes -> full=1, in_ready=0; restart -> addr 0, count 0, full 0, err 0

Source files
------------

// File: rtl/instr_encoder.sv
// Packs an RV32I operation descriptor into a 32-bit instruction word and streams it
// into instruction memory at an auto-incrementing word address.

package instr_encoder_pkg;

  localparam logic [3:0] CLS_OPIMM  = 4'd0;
  localparam logic [3:0] CLS_OP     = 4'd1;
  localparam logic [3:0] CLS_LOAD   = 4'd2;
  localparam logic [3:0] CLS_STORE  = 4'd3;
  localparam logic [3:0] CLS_BRANCH = 4'd4;
  localparam logic [3:0] CLS_JALR   = 4'd5;
  localparam logic [3:0] CLS_JAL    = 4'd6;
  localparam logic [3:0] CLS_LUI    = 4'd7;
  localparam logic [3:0] CLS_AUIPC  = 4'd8;

  localparam logic [6:0] OPC_OPIMM  = 7'h13;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  typedef struct packed {
    logic [3:0]  cls;
    logic [2:0]  funct3;
    logic        alt;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } desc_t;

  typedef struct packed {
    logic        illegal;
    logic [31:0] word;
  } enc_t;

  // Format selection and legality check; illegal descriptors collapse to a NOP.
  function automatic enc_t encode(input desc_t d);
    enc_t       r;
    logic [6:0] f7;
    logic [2:0] f3;
    f3        = d.funct3;
    f7        = {1'b0, d.alt, 5'b0};
    r.illegal = 1'b0;
    r.word    = NOP_WORD;
    case (d.cls)
      CLS_OPIMM: begin
        if (f3 == 3'b001 || f3 == 3'b101)
          r.word = {f7, d.imm[4:0], d.rs1, f3, d.rd, OPC_OPIMM};
        else
          r.word = {d.imm[11:0], d.rs1, f3, d.rd, OPC_OPIMM};
        r.illegal = d.alt && (f3 != 3'b101);
      end
      CLS_OP: begin
        r.word    = {f7, d.rs2, d.rs1, f3, d.rd, OPC_OP};
        r.illegal = d.alt && !(f3 == 3'b000 || f3 == 3'b101);
      end
      CLS_LOAD: begin
        r.word    = {d.imm[11:0], d.rs1, f3, d.rd, OPC_LOAD};
        r.illegal = d.alt || f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111;
      end
      CLS_STORE: begin
        r.word    = {d.imm[11:5], d.rs2, d.rs1, f3, d.imm[4:0], OPC_STORE};
        r.illegal = d.alt || (f3 > 3'b010);
      end
      CLS_BRANCH: begin
        r.word    = {d.imm[12], d.imm[10:5], d.rs2, d.rs1, f3, d.imm[4:1], d.imm[11], OPC_BRANCH};
        r.illegal = d.alt || f3 == 3'b010 || f3 == 3'b011;
      end
      CLS_JALR: begin
        r.word    = {d.imm[11:0], d.rs1, f3, d.rd, OPC_JALR};
        r.illegal = d.alt || (f3 != 3'b000);
      end
      CLS_JAL:   r.word = {d.imm[20], d.imm[10:1], d.imm[11], d.imm[19:12], d.rd, OPC_JAL};
      CLS_LUI:   r.word = {d.imm[31:12], d.rd, OPC_LUI};
      CLS_AUIPC: r.word = {d.imm[31:12], d.rd, OPC_AUIPC};
      default:   r.illegal = 1'b1;
    endcase
    if (r.illegal) r.word = NOP_WORD;
    return r;
  endfunction

endpackage

module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              restart,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_class,
  input  logic [2:0]        in_funct3,
  input  logic              in_alt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  output logic              imem_we,
  input  logic              imem_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  typedef enum logic [1:0] {ST_EMPTY, ST_HOLD, ST_FULL} state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               full_q, full_d;
  logic               err_q, err_d;

  desc_t desc;
  enc_t  enc;
  logic  last_addr;
  logic  done;
  logic  accept;

  assign desc = '{cls: in_class, funct3: in_funct3, alt: in_alt, rd: in_rd,
                  rs1: in_rs1, rs2: in_rs2, imm: in_imm};

  always_comb enc = encode(desc);

  assign last_addr = (addr_q == {ADDR_W{1'b1}});
  assign done      = (state_q == ST_HOLD) && imem_ready;
  // A completion at the top address cannot take a new word: it would have nowhere to go.
  assign in_ready  = !full_q && ((state_q == ST_EMPTY) || (done && !last_addr));
  assign accept    = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      addr_q  <= ADDR_W'(BASE_ADDR);
      wdata_q <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      count_q <= count_d;
      full_q  <= full_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    count_d = count_q;
    full_d  = full_q;
    err_d   = err_q;
    if (restart) begin
      state_d = ST_EMPTY;
      addr_d  = ADDR_W'(BASE_ADDR);
      wdata_d = '0;
      count_d = '0;
      full_d  = 1'b0;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d = ST_HOLD;
            wdata_d = enc.word;
            err_d   = err_q | enc.illegal;
          end
        end
        ST_HOLD: begin
          if (done) begin
            count_d = count_q + CNT_W'(1);
            if (last_addr) begin
              state_d = ST_FULL;
              full_d  = 1'b1;
            end else begin
              addr_d = addr_q + ADDR_W'(1);
              if (accept) begin
                wdata_d = enc.word;
                err_d   = err_q | enc.illegal;
              end else begin
                state_d = ST_EMPTY;
              end
            end
          end
        end
        ST_FULL: state_d = ST_FULL;
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  assign imem_we    = (state_q == ST_HOLD);
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign count      = count_q;
  assign full       = full_q;
  assign err        = err_q;

endmodule
